// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD datapath (decimal counter and converter).
// No logic; parameter defaults size the converter for an 8-digit count.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [BCD_DIGIT_W-1:0] DD_ADJ_THRESH = 4'd8;
  localparam logic [BCD_DIGIT_W-1:0] DD_ADJ_VAL    = 4'd3;

  localparam int DEF_DIGITS = 8;
  localparam int DEF_BIN_W  = 27;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One reverse double-dabble digit correction: subtract 3 when the digit is >= 8.
// Combinational, zero latency, no flow control.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= DD_ADJ_THRESH) ? (digit_i - DD_ADJ_VAL) : digit_i;

endmodule

// File: rtl/bcd_to_bin_converter.sv
// Packed-BCD to binary converter using reverse double-dabble, one shift per cycle.
// Accept-to-done BIN_W+1 cycles (1 on a bad digit); no backpressure, start ignored unless ready.
module bcd_to_bin_converter
  import bcd_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          ready,
  output logic                          done,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          err
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  conv_state_e       state_q, state_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_out_q, bin_out_d;
  logic              err_q, err_d;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       bcd_shift, bcd_adj;
  logic [BIN_W-1:0]       bin_shift;
  logic                   operand_bad;

  // BCD LSB falls into the binary MSB; digits are then corrected independently.
  assign shifted   = {bcd_q, bin_q} >> 1;
  assign bcd_shift = shifted[BCD_W+BIN_W-1:BIN_W];
  assign bin_shift = shifted[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    operand_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) operand_bad = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d = bcd_in;
          bin_d = '0;
          cnt_d = '0;
          if (operand_bad) begin
            state_d   = DONE;
            err_d     = 1'b1;
            bin_out_d = '0;
          end else begin
            state_d = CONV;
          end
        end
      end
      CONV: begin
        bcd_d = bcd_adj;
        bin_d = bin_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          bin_out_d = bin_shift;
          err_d     = 1'b0;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign done    = (state_q == DONE);
  assign bin_out = bin_out_q;
  assign err     = err_q;

endmodule
